fetch_decode_unit: RTL and testbench

Upstream neighbour of the ALU/register-file datapath. Owns the program counter, fetches 32-bit instructions over a variable-latency request/acknowledge instruction-memory port, decodes them into the datapath control fields (register addresses, write enable, operand select, immediate, ALU control), and resolves `bne` using the datapath's `eq` flag. It is a multi-cycle, non-pipelined sequencer: one instruction in flight at a time.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/immGen.sv | 34 +++
 rtl/fetch_decode_unit.sv | 135 +++++++++++++
 tb/tb_fetch_decode_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the fetch/decode sequencer.
// Opcodes, ALU encodings, FSM states, reset IR word.
package riscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;

endpackage

// File: rtl/immGen.sv
// Immediate generator: I-type and B-type sign extension.
// B offset is also produced at PC width for branch targets.
module immGen
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic [31:0]           ir_i,
  output logic [DATA_WIDTH-1:0] imm_i_o,
  output logic [DATA_WIDTH-1:0] imm_b_o,
  output logic [PC_WIDTH-1:0]   br_off_o
);

  logic [11:0] i_raw;
  logic [12:0] b_raw;
  logic        unused_bits;

  assign i_raw = ir_i[31:20];
  assign b_raw = {ir_i[31], ir_i[7],
                  ir_i[30:25], ir_i[11:8],
                  1'b0};

  assign imm_i_o = {{(DATA_WIDTH-12){i_raw[11]}},
                    i_raw};
  assign imm_b_o = {{(DATA_WIDTH-13){b_raw[12]}},
                    b_raw};
  assign br_off_o = {{(PC_WIDTH-13){b_raw[12]}},
                     b_raw};

  // register/opcode fields carry no immediate bits
  assign unused_bits = ^{ir_i[19:12], ir_i[6:0]};

endmodule

// File: rtl/fetch_decode_unit.sv
// Multi-cycle fetch/decode sequencer: one instruction
// in flight, IDLE -> FETCH -> EXEC -> FETCH ...
module fetch_decode_unit
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     eq,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     en,
  output logic                     ALUSrc,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [3:0]               ALU_ctrl,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     illegal
);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_addi, is_add, is_bne;
  logic       is_exec, wr_op;

  logic [DATA_WIDTH-1:0] imm_i, imm_b;
  logic [PC_WIDTH-1:0]   br_off;

  immGen #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_immgen (
    .ir_i     (ir_q),
    .imm_i_o  (imm_i),
    .imm_b_o  (imm_b),
    .br_off_o (br_off)
  );

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];

  assign is_addi = (opc == OPC_OP_IMM) &&
                   (f3 == F3_ADD);
  assign is_add  = (opc == OPC_OP) &&
                   (f3 == F3_ADD) &&
                   (f7 == F7_ADD);
  assign is_bne  = (opc == OPC_BRANCH) &&
                   (f3 == F3_BNE);

  assign is_exec = (state_q == ST_EXEC);
  assign wr_op   = is_addi | is_add;

  assign rs1 = ADDRESS_WIDTH'(ir_q[19:15]);
  assign rs2 = ADDRESS_WIDTH'(ir_q[24:20]);
  assign rd  = ADDRESS_WIDTH'(ir_q[11:7]);

  assign en = is_exec & wr_op &
              (ir_q[11:7] != 5'd0);
  assign illegal = is_exec &
                   ~(wr_op | is_bne);

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  // operand select, ALU op and immediate from IR
  always_comb begin
    ALUSrc   = 1'b0;
    ALU_ctrl = ALU_ADD;
    ImmOp    = '0;
    unique case (1'b1)
      is_addi: begin
        ALUSrc = 1'b1;
        ImmOp  = imm_i;
      end
      is_bne: begin
        ALU_ctrl = ALU_SUB;
        ImmOp    = imm_b;
      end
      default: ;
    endcase
  end

  // sequencer: fetch handshake, IR load, PC update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_bne && !eq)
          pc_d = pc_q + br_off;
        else
          pc_d = pc_q + PC_WIDTH'(4);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, PC and IR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit with an
// expected-result queue popped in each EXEC cycle.
module tb_fetch_decode_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        eq;
  logic [4:0]  rs1, rs2, rd;
  logic        en;
  logic        ALUSrc;
  logic [31:0] ImmOp;
  logic [3:0]  ALU_ctrl;
  logic [31:0] pc;
  logic        illegal;

  fetch_decode_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .eq         (eq),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .en         (en),
    .ALUSrc     (ALUSrc),
    .ImmOp      (ImmOp),
    .ALU_ctrl   (ALU_ctrl),
    .pc         (pc),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic [31:0] en;
    logic [31:0] src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] ill;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mpc;
  exp_t        e;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(
    input int rdv, input int rs1v, input int imm);
    logic [31:0] w;
    logic [31:0] iv;
    iv = imm;
    w = {iv[11:0], 5'(rs1v), 3'b000,
         5'(rdv), 7'b0010011};
    return w;
  endfunction

  function automatic logic [31:0] enc_r(
    input int rdv, input int rs1v, input int rs2v);
    logic [31:0] w;
    w = {7'b0, 5'(rs2v), 5'(rs1v), 3'b000,
         5'(rdv), 7'b0110011};
    return w;
  endfunction

  function automatic logic [31:0] enc_b(
    input int rs1v, input int rs2v, input int off);
    logic [31:0] w;
    logic [31:0] o;
    o = off;
    w = {o[12], o[10:5], 5'(rs2v), 5'(rs1v),
         3'b001, o[4:1], o[11], 7'b1100011};
    return w;
  endfunction

  function automatic exp_t mk_i(input int rdv,
    input int rs1v, input int imm,
    input logic [31:0] p);
    exp_t x;
    logic [31:0] iv;
    iv    = imm;
    x.pc  = p;
    x.rs1 = rs1v;
    x.rs2 = {27'b0, iv[4:0]};
    x.rd  = rdv;
    x.en  = (rdv != 0) ? 32'd1 : 32'd0;
    x.src = 32'd1;
    x.imm = iv;
    x.alu = 32'd0;
    x.ill = 32'd0;
    x.npc = p + 32'd4;
    return x;
  endfunction

  function automatic exp_t mk_r(input int rdv,
    input int rs1v, input int rs2v,
    input logic [31:0] p);
    exp_t x;
    x.pc  = p;
    x.rs1 = rs1v;
    x.rs2 = rs2v;
    x.rd  = rdv;
    x.en  = (rdv != 0) ? 32'd1 : 32'd0;
    x.src = 32'd0;
    x.imm = 32'd0;
    x.alu = 32'd0;
    x.ill = 32'd0;
    x.npc = p + 32'd4;
    return x;
  endfunction

  function automatic exp_t mk_b(input int rs1v,
    input int rs2v, input int off,
    input logic [31:0] p, input logic eqv);
    exp_t x;
    logic [31:0] o;
    o     = off;
    x.pc  = p;
    x.rs1 = rs1v;
    x.rs2 = rs2v;
    x.rd  = {27'b0, o[4:1], o[11]};
    x.en  = 32'd0;
    x.src = 32'd0;
    x.imm = o;
    x.alu = 32'd1;
    x.ill = 32'd0;
    x.npc = eqv ? p + 32'd4 : p + o;
    return x;
  endfunction

  // one FETCH(+waits)/EXEC round trip
  task automatic run(input logic [31:0] w,
                     input exp_t ex, input int waits,
                     input logic eqv, input logic spur);
    exp_t g;
    int   n;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_fetch", 32'(imem_req), 32'd1);
    chk("addr_fetch", imem_addr, ex.pc);
    eq = ~eqv;
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = ~w;
      @(negedge clk);
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("addr_wait", imem_addr, ex.pc);
      chk("en_wait", 32'(en), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    sb.push_back(ex);
    @(negedge clk);
    imem_ack   = spur;
    imem_rdata = ~w;
    eq         = eqv;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk("req_exec", 32'(imem_req), 32'd0);
      chk("pc", pc, g.pc);
      chk("rs1", 32'(rs1), g.rs1);
      chk("rs2", 32'(rs2), g.rs2);
      chk("rd", 32'(rd), g.rd);
      chk("en", 32'(en), g.en);
      chk("ALUSrc", 32'(ALUSrc), g.src);
      chk("ImmOp", ImmOp, g.imm);
      chk("ALU_ctrl", 32'(ALU_ctrl), g.alu);
      chk("illegal", 32'(illegal), g.ill);
      @(negedge clk);
      imem_ack = 1'b0;
      chk("en_after", 32'(en), 32'd0);
      chk("ill_after", 32'(illegal), 32'd0);
      chk("rd_hold", 32'(rd), g.rd);
      chk("req_next", 32'(imem_req), 32'd1);
      chk("next_pc", imem_addr, g.npc);
      mpc = g.npc;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    eq         = 1'b0;
    mpc        = 32'd0;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_rs1", 32'(rs1), 32'd0);
    chk("rst_rs2", 32'(rs2), 32'd0);
    chk("rst_src", 32'(ALUSrc), 32'd1);
    chk("rst_imm", ImmOp, 32'd0);
    chk("rst_alu", 32'(ALU_ctrl), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("idle_ack_ign", 32'(rd), 32'd0);

    e = mk_i(5, 0, 7, mpc);
    run(enc_i(5, 0, 7), e, 0, 1'b0, 1'b0);
    e = mk_i(6, 5, -1, mpc);
    run(enc_i(6, 5, -1), e, 3, 1'b0, 1'b0);
    e = mk_r(0, 1, 2, mpc);
    run(enc_r(0, 1, 2), e, 0, 1'b0, 1'b0);
    e = mk_r(3, 1, 2, mpc);
    run(enc_r(3, 1, 2), e, 1, 1'b0, 1'b0);
    chk("pc_at_bne", mpc, 32'h10);
    e = mk_b(1, 2, -8, mpc, 1'b0);
    run(enc_b(1, 2, -8), e, 0, 1'b0, 1'b0);
    chk("bne_taken", mpc, 32'h08);
    e = mk_i(1, 1, 1, mpc);
    run(enc_i(1, 1, 1), e, 0, 1'b0, 1'b0);
    e = mk_i(2, 2, 2, mpc);
    run(enc_i(2, 2, 2), e, 2, 1'b0, 1'b0);
    e = mk_b(1, 2, -8, mpc, 1'b1);
    run(enc_b(1, 2, -8), e, 0, 1'b1, 1'b0);
    chk("bne_not_taken", mpc, 32'h14);

    e.pc  = mpc;
    e.rs1 = 32'd31;
    e.rs2 = 32'd31;
    e.rd  = 32'd31;
    e.en  = 32'd0;
    e.src = 32'd0;
    e.imm = 32'd0;
    e.alu = 32'd0;
    e.ill = 32'd1;
    e.npc = mpc + 32'd4;
    run(32'hFFFF_FFFF, e, 0, 1'b0, 1'b1);

    e = mk_b(1, 2, -28, mpc, 1'b0);
    run(enc_b(1, 2, -28), e, 1, 1'b0, 1'b0);
    chk("pc_top", mpc, 32'hFFFF_FFFC);
    e = mk_i(7, 0, 1, mpc);
    run(enc_i(7, 0, 1), e, 0, 1'b0, 1'b1);
    chk("pc_wrap", mpc, 32'd0);
    e = mk_i(9, 0, 5, mpc);
    run(enc_i(9, 0, 5), e, 0, 1'b0, 1'b0);

    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_pc", pc, 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    chk("arst_imm", ImmOp, 32'd0);
    chk("arst_src", 32'(ALUSrc), 32'd1);
    chk("arst_en", 32'(en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc   = 32'd0;
    e = mk_i(10, 0, 3, mpc);
    run(enc_i(10, 0, 3), e, 1, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
